// File: rtl/fft_stage_ctrl.sv
// Address/control sequencer for an in-place radix-2 DIT FFT: a bit-reversal swap pass,
// then log2(N) butterfly stages, with a write-back path delayed to match the butterfly.
module fft_stage_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_LOG2N  = 11,
    parameter int BF_LATENCY = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_DATA_LOADED,
    input  logic [ADDR_WIDTH-1:0] i_SAMPLES_NUMBER,
    output logic                  o_RD_EN,
    output logic [ADDR_WIDTH-1:0] o_RD_ADDR_A,
    output logic [ADDR_WIDTH-1:0] o_RD_ADDR_B,
    output logic [MAX_LOG2N-2:0]  o_TW_ADDR,
    output logic                  o_BF_BYPASS,
    output logic                  o_WR_EN,
    output logic [ADDR_WIDTH-1:0] o_WR_ADDR_A,
    output logic [ADDR_WIDTH-1:0] o_WR_ADDR_B,
    output logic [3:0]            o_STAGE,
    output logic                  o_BUSY,
    output logic                  o_CALC_END,
    output logic                  o_ERR
);

    localparam int D    = 1 + BF_LATENCY;
    localparam int LW   = 4;
    localparam int TW_W = MAX_LOG2N - 1;
    localparam logic [ADDR_WIDTH:0] N_MAX = (ADDR_WIDTH + 1)'(1) << MAX_LOG2N;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BITREV,
        S_DRAIN,
        S_STAGE,
        S_DONE
    } state_t;

    function automatic logic [LW-1:0] log2_of(input logic [ADDR_WIDTH-1:0] n);
        logic [LW-1:0] r;
        r = '0;
        for (int b = 0; b < ADDR_WIDTH; b++) begin
            if (n[b]) r = LW'(b);
        end
        return r;
    endfunction

    function automatic logic n_is_valid(input logic [ADDR_WIDTH-1:0] n);
        return ($countones(n) == 1) && (n >= ADDR_WIDTH'(4)) && ({1'b0, n} <= N_MAX);
    endfunction

    // Reverse the full MAX_LOG2N-bit field, then shift so only the low l bits remain reversed.
    function automatic logic [ADDR_WIDTH-1:0] bit_rev(input logic [MAX_LOG2N-1:0] v,
                                                      input logic [LW-1:0] l);
        logic [MAX_LOG2N-1:0] r;
        for (int b = 0; b < MAX_LOG2N; b++) begin
            r[MAX_LOG2N-1-b] = v[b];
        end
        return ADDR_WIDTH'(r >> (LW'(MAX_LOG2N) - l));
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] n_q, n_d;
    logic [LW-1:0]         l_q, l_d;
    logic [LW-1:0]         stage_q, stage_d;
    logic                  from_br_q, from_br_d;
    logic                  calc_end_q, calc_end_d;
    logic                  err_q, err_d;
    logic                  rej_q, rej_d;

    logic                  start;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_a, rd_b;
    logic [TW_W-1:0]       tw;
    logic                  bypass;
    logic [ADDR_WIDTH-1:0] span, pos, bf_a, rev;
    logic [LW-1:0]         tw_sh;

    logic [D-1:0]          wr_vld_q;
    logic [ADDR_WIDTH-1:0] wr_a_q [D];
    logic [ADDR_WIDTH-1:0] wr_b_q [D];

    assign start = i_DATA_LOADED && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        l_d        = l_q;
        stage_d    = stage_q;
        from_br_d  = from_br_q;
        calc_end_d = calc_end_q;
        err_d      = err_q;
        rej_d      = rej_q;
        rd_en      = 1'b0;
        rd_a       = '0;
        rd_b       = '0;
        tw         = '0;
        bypass     = 1'b0;

        span  = ADDR_WIDTH'(1) << stage_q;
        pos   = cnt_q & (span - ADDR_WIDTH'(1));
        bf_a  = ((cnt_q >> stage_q) << (stage_q + LW'(1))) | pos;
        tw_sh = l_q - stage_q - LW'(1);
        rev   = bit_rev(cnt_q[MAX_LOG2N-1:0], l_q);

        unique case (state_q)
            S_IDLE: ;
            S_DONE: begin
                // A rejected length lands here with the flags still low; raise them one cycle later.
                if (!calc_end_q) begin
                    calc_end_d = 1'b1;
                    err_d      = rej_q;
                end
            end
            S_BITREV: begin
                if (cnt_q < rev) begin
                    rd_en  = 1'b1;
                    rd_a   = cnt_q;
                    rd_b   = rev;
                    bypass = 1'b1;
                end
                if (cnt_q == n_q - ADDR_WIDTH'(1)) begin
                    state_d   = S_DRAIN;
                    cnt_d     = '0;
                    from_br_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            S_STAGE: begin
                rd_en = 1'b1;
                rd_a  = bf_a;
                rd_b  = bf_a + span;
                tw    = TW_W'(pos << tw_sh);
                if (cnt_q == (n_q >> 1) - ADDR_WIDTH'(1)) begin
                    state_d   = S_DRAIN;
                    cnt_d     = '0;
                    from_br_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == ADDR_WIDTH'(D - 1)) begin
                    cnt_d = '0;
                    if (from_br_q) begin
                        state_d = S_STAGE;
                        stage_d = '0;
                    end else if (stage_q == l_q - LW'(1)) begin
                        state_d    = S_DONE;
                        calc_end_d = 1'b1;
                        err_d      = 1'b0;
                    end else begin
                        state_d = S_STAGE;
                        stage_d = stage_q + LW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: ;
        endcase

        if (start) begin
            n_d        = i_SAMPLES_NUMBER;
            l_d        = log2_of(i_SAMPLES_NUMBER);
            cnt_d      = '0;
            stage_d    = '0;
            calc_end_d = 1'b0;
            err_d      = 1'b0;
            if (n_is_valid(i_SAMPLES_NUMBER)) begin
                state_d = S_BITREV;
                rej_d   = 1'b0;
            end else begin
                state_d = S_DONE;
                rej_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            l_q        <= '0;
            stage_q    <= '0;
            from_br_q  <= 1'b0;
            calc_end_q <= 1'b0;
            err_q      <= 1'b0;
            rej_q      <= 1'b0;
            wr_vld_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            l_q        <= l_d;
            stage_q    <= stage_d;
            from_br_q  <= from_br_d;
            calc_end_q <= calc_end_d;
            err_q      <= err_d;
            rej_q      <= rej_d;
            wr_vld_q   <= {wr_vld_q[D-2:0], rd_en};
        end
    end

    // Address shadow of the butterfly pipeline; only the valid bits need clearing.
    always_ff @(posedge i_clk) begin
        wr_a_q[0] <= rd_a;
        wr_b_q[0] <= rd_b;
        for (int j = 1; j < D; j++) begin
            wr_a_q[j] <= wr_a_q[j-1];
            wr_b_q[j] <= wr_b_q[j-1];
        end
    end

    assign o_RD_EN     = rd_en;
    assign o_RD_ADDR_A = rd_a;
    assign o_RD_ADDR_B = rd_b;
    assign o_TW_ADDR   = tw;
    assign o_BF_BYPASS = bypass;
    assign o_WR_EN     = wr_vld_q[D-1];
    assign o_WR_ADDR_A = wr_vld_q[D-1] ? wr_a_q[D-1] : '0;
    assign o_WR_ADDR_B = wr_vld_q[D-1] ? wr_b_q[D-1] : '0;
    assign o_STAGE     = stage_q;
    assign o_BUSY      = (state_q == S_BITREV) || (state_q == S_DRAIN) || (state_q == S_STAGE);
    assign o_CALC_END  = calc_end_q;
    assign o_ERR       = err_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl: expected RAM reads/writes are queued with their
// absolute cycle and popped by a monitor whenever the DUT strobes o_RD_EN or o_WR_EN.
module tb_fft_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_DATA_LOADED;
    logic [11:0] i_SAMPLES_NUMBER;
    logic        o_RD_EN;
    logic [11:0] o_RD_ADDR_A, o_RD_ADDR_B;
    logic [9:0]  o_TW_ADDR;
    logic        o_BF_BYPASS;
    logic        o_WR_EN;
    logic [11:0] o_WR_ADDR_A, o_WR_ADDR_B;
    logic [3:0]  o_STAGE;
    logic        o_BUSY, o_CALC_END, o_ERR;

    fft_stage_ctrl dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_DATA_LOADED    (i_DATA_LOADED),
        .i_SAMPLES_NUMBER (i_SAMPLES_NUMBER),
        .o_RD_EN          (o_RD_EN),
        .o_RD_ADDR_A      (o_RD_ADDR_A),
        .o_RD_ADDR_B      (o_RD_ADDR_B),
        .o_TW_ADDR        (o_TW_ADDR),
        .o_BF_BYPASS      (o_BF_BYPASS),
        .o_WR_EN          (o_WR_EN),
        .o_WR_ADDR_A      (o_WR_ADDR_A),
        .o_WR_ADDR_B      (o_WR_ADDR_B),
        .o_STAGE          (o_STAGE),
        .o_BUSY           (o_BUSY),
        .o_CALC_END       (o_CALC_END),
        .o_ERR            (o_ERR)
    );

    always #5 clk = ~clk;

    typedef struct {int c; int a; int b; int tw; bit byp;} rd_t;
    typedef struct {int c; int a; int b;} wr_t;

    rd_t rd_q[$];
    wr_t wr_q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  wr_cut = 1 << 30;
    rd_t er;
    wr_t ew;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_RD_EN) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_bad++;
                $display("FAIL rd_unexpected: cycle %0d got A=%0d B=%0d, required no read",
                         cyc, o_RD_ADDR_A, o_RD_ADDR_B);
            end else begin
                er = rd_q.pop_front();
                if (er.c != cyc || er.a != int'(o_RD_ADDR_A) || er.b != int'(o_RD_ADDR_B) ||
                    er.tw != int'(o_TW_ADDR) || er.byp != o_BF_BYPASS) begin
                    n_bad++;
                    $display("FAIL rd: got cyc=%0d A=%0d B=%0d tw=%0d byp=%0d, required cyc=%0d A=%0d B=%0d tw=%0d byp=%0d",
                             cyc, o_RD_ADDR_A, o_RD_ADDR_B, o_TW_ADDR, o_BF_BYPASS,
                             er.c, er.a, er.b, er.tw, er.byp);
                end
            end
        end
        if (o_WR_EN) begin
            n_cmp++;
            if (wr_q.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected: cycle %0d got A=%0d B=%0d, required no write",
                         cyc, o_WR_ADDR_A, o_WR_ADDR_B);
            end else begin
                ew = wr_q.pop_front();
                if (ew.c != cyc || ew.a != int'(o_WR_ADDR_A) || ew.b != int'(o_WR_ADDR_B)) begin
                    n_bad++;
                    $display("FAIL wr: got cyc=%0d A=%0d B=%0d, required cyc=%0d A=%0d B=%0d",
                             cyc, o_WR_ADDR_A, o_WR_ADDR_B, ew.c, ew.a, ew.b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Read at cycle c implies the in-place write 5 cycles later (RAM 1 + butterfly 4).
    task automatic exp_rd(input int c, input int a, input int b, input int tw, input bit byp);
        rd_t r;
        wr_t w;
        r.c = c; r.a = a; r.b = b; r.tw = tw; r.byp = byp;
        rd_q.push_back(r);
        if (c + 5 < wr_cut) begin
            w.c = c + 5; w.a = a; w.b = b;
            wr_q.push_back(w);
        end
    endtask

    task automatic pulse(input logic [11:0] n);
        i_DATA_LOADED    = 1'b1;
        i_SAMPLES_NUMBER = n;
        tick();
        i_DATA_LOADED    = 1'b0;
    endtask

    task automatic wait_calc_end(input string name, input int t0, input int req);
        int t_start;
        t_start = cyc;
        while (!o_CALC_END && (cyc - t_start) < 300) tick();
        check(name, o_CALC_END ? (cyc - t0) : -1, req);
    endtask

    function automatic int out_bits();
        return $countones({o_RD_EN, o_RD_ADDR_A, o_RD_ADDR_B, o_TW_ADDR, o_BF_BYPASS, o_WR_EN,
                           o_WR_ADDR_A, o_WR_ADDR_B, o_STAGE, o_BUSY, o_CALC_END, o_ERR});
    endfunction

    int t0;
    int s1_n8 [4][3] = '{'{0, 2, 0}, '{1, 3, 2}, '{4, 6, 0}, '{5, 7, 2}};
    int br_n16 [6][2] = '{'{1, 8}, '{2, 4}, '{3, 12}, '{5, 10}, '{7, 14}, '{11, 13}};
    int bad_n [4] = '{6, 4096, 2, 3072};  // 4096 does not fit 12 bits and arrives as 0
    int acc;

    initial begin
        rst = 1'b1;
        i_DATA_LOADED = 1'b0;
        i_SAMPLES_NUMBER = '0;
        repeat (3) tick();
        rst = 1'b0;

        acc = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            acc += out_bits();
        end
        check("idle_outputs_zero", acc, 0);

        // N=8 full run with a stray start pulse mid-run
        t0 = cyc;
        exp_rd(t0 + 2, 1, 4, 0, 1);
        exp_rd(t0 + 4, 3, 6, 0, 1);
        for (int k = 0; k < 4; k++) exp_rd(t0 + 14 + k, 2 * k, 2 * k + 1, 0, 0);
        for (int k = 0; k < 4; k++) exp_rd(t0 + 23 + k, s1_n8[k][0], s1_n8[k][1], s1_n8[k][2], 0);
        for (int k = 0; k < 4; k++) exp_rd(t0 + 32 + k, k, k + 4, k, 0);
        pulse(12'd8);
        check("n8_busy_after_start", o_BUSY, 1);
        run_to(t0 + 12);
        check("n8_stage_bitrev_drain", o_STAGE, 0);
        run_to(t0 + 20);
        pulse(12'd4);
        check("n8_stage0_drain", o_STAGE, 0);
        run_to(t0 + 24);
        check("n8_stage1", o_STAGE, 1);
        run_to(t0 + 38);
        check("n8_stage2_drain", o_STAGE, 2);
        wait_calc_end("n8_calc_end_cycle", t0, 41);
        check("n8_err", o_ERR, 0);
        check("n8_busy_done", o_BUSY, 0);
        check("n8_rd_all_seen", rd_q.size(), 0);
        check("n8_wr_all_seen", wr_q.size(), 0);
        repeat (3) tick();

        // Rejected lengths: flags drop, then rise together two cycles after start
        for (int j = 0; j < 4; j++) begin
            t0 = cyc;
            pulse(12'(bad_n[j]));
            check("bad_n_calc_end_drop", o_CALC_END, 0);
            check("bad_n_err_drop", o_ERR, 0);
            tick();
            check("bad_n_calc_end", o_CALC_END, 1);
            check("bad_n_err", o_ERR, 1);
            check("bad_n_busy", o_BUSY, 0);
            repeat (2) tick();
        end

        // N=4 restart from DONE
        t0 = cyc;
        exp_rd(t0 + 2, 1, 2, 0, 1);
        exp_rd(t0 + 10, 0, 1, 0, 0);
        exp_rd(t0 + 11, 2, 3, 0, 0);
        exp_rd(t0 + 17, 0, 2, 0, 0);
        exp_rd(t0 + 18, 1, 3, 1, 0);
        pulse(12'd4);
        check("n4_calc_end_drop", o_CALC_END, 0);
        check("n4_err_drop", o_ERR, 0);
        wait_calc_end("n4_calc_end_cycle", t0, 24);
        check("n4_err", o_ERR, 0);
        check("n4_rd_all_seen", rd_q.size(), 0);
        check("n4_wr_all_seen", wr_q.size(), 0);
        repeat (2) tick();

        // N=16 aborted by reset during stage 1; in-flight writes must vanish
        t0 = cyc;
        wr_cut = t0 + 38;
        for (int j = 0; j < 6; j++) exp_rd(t0 + 1 + br_n16[j][0], br_n16[j][0], br_n16[j][1], 0, 1);
        for (int k = 0; k < 8; k++) exp_rd(t0 + 22 + k, 2 * k, 2 * k + 1, 0, 0);
        exp_rd(t0 + 35, 0, 2, 0, 0);
        exp_rd(t0 + 36, 1, 3, 4, 0);
        exp_rd(t0 + 37, 4, 6, 0, 0);
        pulse(12'd16);
        run_to(t0 + 36);
        check("n16_stage1", o_STAGE, 1);
        run_to(t0 + 37);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_outputs_zero", out_bits(), 0);
        acc = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            acc += out_bits();
        end
        check("post_rst_outputs_zero", acc, 0);
        check("n16_rd_all_seen", rd_q.size(), 0);
        check("n16_wr_all_seen", wr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
